// File: rtl/fib_pkg.sv
// Shared constants and helpers for the Fibonacci adder, sequencer and result buffer.
package fib_pkg;

  localparam int FIB_DATA_W = 17;
  localparam int FIB_N_W    = 5;
  localparam int FIB_N_MAX  = 24;

  // Smallest r with 2**r >= n; used for pointer and occupancy widths.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fib_result_buffer_if.sv
// Consumer-side result stream of fib_result_buffer. FIB_BUF_PARITY_EN adds out_parity.
interface fib_result_buffer_if #(
  parameter int DATA_W = 17
);

  // Transfer happens on a rising clk edge where out_valid & out_ready; out_valid never
  // waits on out_ready, and out_data/out_parity stay stable while out_valid & ~out_ready.
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef FIB_BUF_PARITY_EN
  logic              out_parity;
`endif

  modport master (
    output out_valid,
    output out_data,
`ifdef FIB_BUF_PARITY_EN
    output out_parity,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
`ifdef FIB_BUF_PARITY_EN
    input  out_parity,
`endif
    output out_ready
  );

endinterface

// File: rtl/fib_rise_detect.sv
// Rising-edge detector for an adder done level. done_q resets to 1 so a done that is
// already high when reset releases does not count as a new completion.
module fib_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic done_i,
  output logic cap_o
);

  logic done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b1;
    else        done_q <= done_i;
  end

  assign cap_o = done_i & ~done_q;

endmodule

// File: rtl/fib_result_buffer.sv
// Captures one adder result per done rising edge into a DEPTH-entry FIFO and presents it
// over valid/ready. Define FIB_BUF_PARITY_EN to store and present an even-parity bit.
module fib_result_buffer
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done,
  input  logic [DATA_W-1:0]      dataIn,
  fib_result_buffer_if.master    out_if,
  output logic [clog2(DEPTH):0]  count,
  output logic                   full,
  output logic                   overflow
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef FIB_BUF_PARITY_EN
  localparam int ENTRY_W = DATA_W + 1;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  logic               cap;
  logic               pop;
  logic               wr_en;
  logic               empty;
  logic [ENTRY_W-1:0] entry_d;
  logic [ENTRY_W-1:0] head_entry;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  fib_rise_detect u_rise (
    .clk    (clk),
    .rst_n  (reset),
    .done_i (done),
    .cap_o  (cap)
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign pop   = ~empty & out_if.out_ready;
  // A pop in the same cycle frees the head slot, so a capture while full still lands.
  assign wr_en = cap & (~full | pop);

`ifdef FIB_BUF_PARITY_EN
  assign entry_d = {^dataIn, dataIn};
`else
  assign entry_d = dataIn;
`endif

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pop)   head_d = head_q + PTR_W'(1);
    if (wr_en) tail_d = tail_q + PTR_W'(1);
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    if (cap & full & ~pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: every read is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail_q] <= entry_d;
  end

  assign head_entry       = empty ? '0 : mem_q[head_q];
  assign out_if.out_valid = ~empty;
  assign out_if.out_data  = head_entry[DATA_W-1:0];
`ifdef FIB_BUF_PARITY_EN
  assign out_if.out_parity = head_entry[DATA_W];
`endif

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fib_result_buffer.sv
// Directed bench for fib_result_buffer: reset behaviour, capture latency, overflow,
// simultaneous capture/pop while full, pointer wrap and asynchronous reset.
module tb_fib_result_buffer;
  import fib_pkg::*;

  localparam int DATA_W = 17;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              done;
  logic [DATA_W-1:0] dataIn;
  logic [2:0]        count;
  logic              full;
  logic              overflow;

  logic [DATA_W-1:0] exp_q[$];
  int                n_checks;
  int                n_errors;

  fib_result_buffer_if #(.DATA_W(DATA_W)) out_if ();

  fib_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .done     (done),
    .dataIn   (dataIn),
    .out_if   (out_if),
    .count    (count),
    .full     (full),
    .overflow (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [DATA_W-1:0] v, input bit expect_kept);
    dataIn = v;
    done   = 1'b1;
    step();
    done   = 1'b0;
    if (expect_kept) exp_q.push_back(v);
    step();
  endtask

  task automatic drain(input string tag);
    logic [DATA_W-1:0] e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(out_if.out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_if.out_data), 32'(e));
      out_if.out_ready = 1'b1;
      step();
      out_if.out_ready = 1'b0;
    end
    check({tag, "_empty_valid"}, 32'(out_if.out_valid), 32'd0);
    check({tag, "_empty_data"}, 32'(out_if.out_data), 32'd0);
    check({tag, "_empty_count"}, 32'(count), 32'd0);
  endtask

  task automatic pulse_reset();
    done = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    exp_q.delete();
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    done = 1'b1;
    dataIn = '0;
    out_if.out_ready = 1'b0;

    // 1: reset with done held high; release must not capture
    step();
    step();
    check("t1_rst_count", 32'(count), 32'd0);
    check("t1_rst_valid", 32'(out_if.out_valid), 32'd0);
    reset = 1'b1;
    repeat (3) step();
    check("t1_count", 32'(count), 32'd0);
    check("t1_valid", 32'(out_if.out_valid), 32'd0);
    check("t1_data", 32'(out_if.out_data), 32'd0);
    check("t1_full", 32'(full), 32'd0);
    check("t1_overflow", 32'(overflow), 32'd0);

    // 2: single capture, 1-cycle latency, done held high
    done = 1'b0;
    step();
    dataIn = 17'd75025;
    done = 1'b1;
    step();
    check("t2_valid", 32'(out_if.out_valid), 32'd1);
    check("t2_data", 32'(out_if.out_data), 32'd75025);
    check("t2_count", 32'(count), 32'd1);
`ifdef FIB_BUF_PARITY_EN
    check("t2_parity", 32'(out_if.out_parity), 32'd0);
`endif
    repeat (10) step();
    check("t2_held_count", 32'(count), 32'd1);
    done = 1'b0;
    step();
    exp_q.push_back(17'd75025);
    drain("t2_drain");

    // 3: fill, overflow on a fifth capture, drain in order
    capture(17'd1, 1'b1);
    capture(17'd2, 1'b1);
    capture(17'd3, 1'b1);
    capture(17'd5, 1'b1);
    check("t3_full", 32'(full), 32'd1);
    check("t3_count", 32'(count), 32'd4);
    check("t3_ovf_before", 32'(overflow), 32'd0);
`ifdef FIB_BUF_PARITY_EN
    check("t3_parity_head", 32'(out_if.out_parity), 32'd1);
`endif
    capture(17'd8, 1'b0);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_count_after", 32'(count), 32'd4);
    drain("t3_drain");
    check("t3_ovf_sticky", 32'(overflow), 32'd1);

    // 4: full, capture and pop in the same cycle
    pulse_reset();
    check("t4_ovf_cleared", 32'(overflow), 32'd0);
    capture(17'd1, 1'b1);
    capture(17'd2, 1'b1);
    capture(17'd3, 1'b1);
    capture(17'd5, 1'b1);
    check("t4_full", 32'(full), 32'd1);
    check("t4_head", 32'(out_if.out_data), 32'(exp_q.pop_front()));
    dataIn = 17'd8;
    done = 1'b1;
    out_if.out_ready = 1'b1;
    exp_q.push_back(17'd8);
    step();
    done = 1'b0;
    out_if.out_ready = 1'b0;
    check("t4_count", 32'(count), 32'd4);
    check("t4_overflow", 32'(overflow), 32'd0);
    step();
    drain("t4_drain");

    // 5: ten capture/pop pairs, pointers wrap
    for (int i = 0; i < 10; i++) begin
      dataIn = DATA_W'(100 + i * 7);
      done = 1'b1;
      step();
      done = 1'b0;
      check("t5_count_one", 32'(count), 32'd1);
      check("t5_data", 32'(out_if.out_data), 32'(100 + i * 7));
      out_if.out_ready = 1'b1;
      step();
      out_if.out_ready = 1'b0;
      check("t5_count_zero", 32'(count), 32'd0);
      step();
    end

    // 6: asynchronous reset mid-operation
    capture(17'd11, 1'b1);
    capture(17'd22, 1'b1);
    capture(17'd33, 1'b1);
    check("t6_count3", 32'(count), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("t6_async_count", 32'(count), 32'd0);
    check("t6_async_valid", 32'(out_if.out_valid), 32'd0);
    check("t6_async_data", 32'(out_if.out_data), 32'd0);
    check("t6_async_full", 32'(full), 32'd0);
`ifdef FIB_BUF_PARITY_EN
    check("t6_async_parity", 32'(out_if.out_parity), 32'd0);
`endif
    exp_q.delete();
    step();
    reset = 1'b1;
    step();
    capture(17'd44, 1'b1);
    check("t6_count1", 32'(count), 32'd1);
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
